// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the bus sequencer.
// Select code values and the FSM state encoding.
package bus_sequencer_pkg;

  localparam int SELW = 3;

  localparam logic [SELW-1:0] SRC_A  = 3'd0;
  localparam logic [SELW-1:0] SRC_B  = 3'd1;
  localparam logic [SELW-1:0] SRC_IN = 3'd2;

  localparam logic [SELW-1:0] DST_A   = 3'd0;
  localparam logic [SELW-1:0] DST_B   = 3'd1;
  localparam logic [SELW-1:0] DST_OUT = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/bus_sequencer_cmd_fifo.sv
// Command FIFO: power-of-2 depth, separate count.
// Head entry is visible combinationally on rdata.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Register-transfer sequencer: queues commands and
// drives datapath selects/enables in two phases.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SELW  = bus_sequencer_pkg::SELW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  input  logic            halt,
  output logic [SELW-1:0] selsrc,
  output logic            srcen,
  output logic [SELW-1:0] seldst,
  output logic            dsten,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2*SELW-1:0] head;
  logic [SELW-1:0]   head_src, head_dst;
  logic              full, empty;
  logic [CW-1:0]     count;
  logic              push, pop, legal;

  state_t          state_q, state_d;
  logic [SELW-1:0] selsrc_q, selsrc_d;
  logic [SELW-1:0] seldst_q, seldst_d;
  logic            srcen_q, srcen_d;
  logic            dsten_q, dsten_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (2*SELW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_src, cmd_dst}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_src  = head[2*SELW-1:SELW];
  assign head_dst  = head[SELW-1:0];
  assign legal     = (head_src <= SELW'(SRC_IN)) &&
                     (head_dst <= SELW'(DST_OUT));
  assign cmd_ready = rdy_q & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = ~empty & ~halt &
                     ((state_q == ST_IDLE) ||
                      (state_q == ST_LATCH));
  assign busy      = (state_q != ST_IDLE) | (count != '0);

  assign selsrc = selsrc_q;
  assign seldst = seldst_q;
  assign srcen  = srcen_q;
  assign dsten  = dsten_q;
  assign done   = done_q;
  assign err    = err_q;

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    selsrc_d = selsrc_q;
    seldst_d = seldst_q;
    srcen_d  = 1'b0;
    dsten_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdy_d    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (legal) begin
            state_d  = ST_DRIVE;
            selsrc_d = head_src;
            seldst_d = head_dst;
            srcen_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        state_d = ST_LATCH;
        srcen_d = 1'b1;
        dsten_d = 1'b1;
      end
      ST_LATCH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (pop) begin
          if (legal) begin
            state_d  = ST_DRIVE;
            selsrc_d = head_src;
            seldst_d = head_dst;
            srcen_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      selsrc_q <= '0;
      seldst_q <= '0;
      srcen_q  <= 1'b0;
      dsten_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      selsrc_q <= selsrc_d;
      seldst_q <= seldst_d;
      srcen_q  <= srcen_d;
      dsten_q  <= dsten_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer.
// Inputs change and outputs sample 1ns after rising edges.
module tb_bus_sequencer;

  logic       clk, rst, cmd_valid, cmd_ready, halt;
  logic [2:0] cmd_src, cmd_dst, selsrc, seldst;
  logic       srcen, dsten, busy, done, err;

  int vec  = 0;
  int miss = 0;

  bus_sequencer #(.DEPTH(4), .SELW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .halt      (halt),
    .selsrc    (selsrc),
    .srcen     (srcen),
    .seldst    (seldst),
    .dsten     (dsten),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v,
                     input logic [2:0] s,
                     input logic [2:0] d);
    cmd_valid = v;
    cmd_src   = s;
    cmd_dst   = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outs"},
        {selsrc, seldst, srcen, dsten,
         busy, done, err, cmd_ready}, 32'h0);
  endtask

  logic [7:0] s_bits, d_bits, n_bits;
  logic [5:0] sel_at [8];
  logic [5:0] got [4];
  int         n;

  initial begin
    rst  = 1'b0;
    halt = 1'b0;
    put(1'b1, 3'd0, 3'd1);

    // Reset held with cmd_valid asserted
    #2;
    chk_all_zero("rst_early");
    tick; tick; tick;
    chk_all_zero("rst_held");
    rst = 1'b1;
    put(1'b0, 3'd0, 3'd0);
    tick;
    chk("rel_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);
    tick; tick;
    chk("rel_idle", {srcen, dsten, busy, done}, 0);

    // Single transfer 2 -> 0
    put(1'b1, 3'd2, 3'd0);
    tick;
    put(1'b0, 3'd0, 3'd0);
    chk("s_k", {busy, srcen}, 2'b10);
    tick;
    chk("s_k1", {selsrc, seldst, srcen, dsten},
        {3'd2, 3'd0, 1'b1, 1'b0});
    tick;
    chk("s_k2", {selsrc, seldst, srcen, dsten},
        {3'd2, 3'd0, 1'b1, 1'b1});
    chk("s_k2_done", done, 0);
    tick;
    chk("s_k3", {done, srcen, dsten}, 3'b100);
    chk("s_k3_sel", {selsrc, seldst},
        {3'd2, 3'd0});
    tick;
    chk("s_k4", {done, busy, srcen}, 3'b000);

    // Back-to-back 0->1, 1->2, 2->0
    put(1'b1, 3'd0, 3'd1);
    tick;
    s_bits = '0;
    d_bits = '0;
    n_bits = '0;
    for (int i = 1; i < 8; i++) begin
      if (i == 1) put(1'b1, 3'd1, 3'd2);
      if (i == 2) put(1'b1, 3'd2, 3'd0);
      if (i == 3) put(1'b0, 3'd0, 3'd0);
      tick;
      s_bits[i] = srcen;
      d_bits[i] = dsten;
      n_bits[i] = done;
      sel_at[i] = {selsrc, seldst};
    end
    chk("b2b_srcen", s_bits, 8'b0111_1110);
    chk("b2b_dsten", d_bits, 8'b0101_0100);
    chk("b2b_done", n_bits, 8'b1010_1000);
    chk("b2b_sel1", sel_at[1], {3'd0, 3'd1});
    chk("b2b_sel2", sel_at[2], {3'd0, 3'd1});
    chk("b2b_sel3", sel_at[3], {3'd1, 3'd2});
    chk("b2b_sel5", sel_at[5], {3'd2, 3'd0});
    chk("b2b_sel6", sel_at[6], {3'd2, 3'd0});
    tick;
    chk("b2b_end", {busy, done}, 0);

    // Backpressure with halt
    halt = 1'b1;
    put(1'b1, 3'd0, 3'd1); tick;
    put(1'b1, 3'd1, 3'd0); tick;
    put(1'b1, 3'd2, 3'd1); tick;
    chk("full_ready3", cmd_ready, 1);
    put(1'b1, 3'd0, 3'd2); tick;
    chk("full_ready", cmd_ready, 0);
    put(1'b1, 3'd1, 3'd1); tick;
    chk("full_hold", {cmd_ready, busy, srcen},
        3'b010);
    put(1'b0, 3'd0, 3'd0);
    halt = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (dsten) begin
        if (n < 4) got[n] = {selsrc, seldst};
        n++;
        chk("full_en", srcen, 1);
      end
    end
    chk("full_n", n, 4);
    chk("full_o0", got[0], {3'd0, 3'd1});
    chk("full_o1", got[1], {3'd1, 3'd0});
    chk("full_o2", got[2], {3'd2, 3'd1});
    chk("full_o3", got[3], {3'd0, 3'd2});
    chk("full_end", {busy, cmd_ready}, 2'b01);

    // Illegal source then legal 0->2
    put(1'b1, 3'd5, 3'd1);
    tick;
    put(1'b1, 3'd0, 3'd2);
    tick;
    put(1'b0, 3'd0, 3'd0);
    chk("ill_err", {err, srcen, dsten}, 3'b100);
    tick;
    chk("ill_k2", {err, srcen, dsten}, 3'b010);
    chk("ill_sel", {selsrc, seldst},
        {3'd0, 3'd2});
    tick;
    chk("ill_k3", {err, dsten}, 2'b01);
    tick;
    chk("ill_done", {done, err}, 2'b10);
    tick;
    chk("ill_end", {busy, err}, 0);

    // Reset during LATCH with two queued
    put(1'b1, 3'd0, 3'd1); tick;
    put(1'b1, 3'd1, 3'd0); tick;
    put(1'b1, 3'd2, 3'd1); tick;
    put(1'b0, 3'd0, 3'd0);
    chk("mr_latch", {srcen, dsten}, 2'b11);
    rst = 1'b0;
    #1;
    chk_all_zero("mr_async");
    tick;
    rst = 1'b1;
    tick;
    chk("mr_busy", busy, 0);
    s_bits = '0;
    for (int c = 0; c < 6; c++) begin
      tick;
      s_bits[c] = srcen | dsten | done | busy;
    end
    chk("mr_quiet", s_bits, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control-side counterpart of the register/bus datapath. Accepts queued register-transfer commands (source code, destination code) over a valid/ready handshake.
- Drives the datapath select/enable lines (selsrc, srcen, seldst, dsten) with a fixed two-phase timing per transfer.
- Sits between the MARIE control FSM (or a test host) and the datapath. Buffers commands so the issuer need not track bus timing.

Parameters:
- DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- SELW, 3, width of source/destination select codes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  issuer presents a command.
- cmd_ready  output  1  FIFO can accept; high exactly when FIFO not full and rst deasserted.
- cmd_src  input  SELW  source code: 0=reg A, 1=reg B, 2=input port; 3..7 illegal.
- cmd_dst  input  SELW  destination code: 0=reg A, 1=reg B, 2=output port; 3..7 illegal.
- halt  input  1  when high, no new command is popped; an in-flight transfer completes.
- selsrc  output  SELW  source select to datapath.
- srcen  output  1  source drive enable to datapath.
- seldst  output  SELW  destination select to datapath.
- dsten  output  1  destination latch enable to datapath.
- busy  output  1  high when state != IDLE or FIFO non-empty.
- done  output  1  one-cycle pulse, cycle after a transfer's LATCH phase.
- err  output  1  one-cycle pulse when an illegal command is popped and discarded.

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers/count 0, state IDLE.
  - All outputs 0: selsrc, seldst, srcen, dsten, busy, done, err, cmd_ready.
  - Release is synchronous to clk; cmd_ready rises in the first cycle after release.
- Push: cmd_valid & cmd_ready at a rising edge writes {cmd_src, cmd_dst} at the write pointer.
  - Pointers wrap modulo DEPTH; count tracked separately to distinguish full from empty.
- Pop and push in the same cycle are allowed when not full; count is unchanged.
- No push when full; cmd_ready is low, and no bypass path exists.
- All datapath outputs are registered.
- FSM states: IDLE, DRIVE, LATCH.
- IDLE:
  - If FIFO non-empty and halt=0, pop the head.
  - Legal head: next state DRIVE; selsrc/seldst load the codes, srcen=1, dsten=0.
  - Illegal head (either code >2): discard, pulse err next cycle, stay IDLE, all enables 0.
- DRIVE: one cycle of bus settling. Next state LATCH; srcen=1, dsten=1, selects held.
- LATCH: destination captures at the end of this cycle. Next cycle done=1, then:
  - FIFO non-empty and halt=0 and legal head: pop and go directly to DRIVE (back-to-back; srcen stays 1, selects change, dsten=0).
  - Otherwise: IDLE; srcen=0, dsten=0. Selects hold their last values.
  - An illegal head popped here pulses err, and the next state is IDLE.
- Latency: command accepted at edge k → DRIVE visible after edge k+1 → LATCH after edge k+2 → done high after edge k+3.
- Throughput: one transfer per 2 cycles sustained.
- dsten is never high without srcen high in the same cycle.
- selsrc/seldst never change while dsten=1.
- halt asserted during DRIVE or LATCH does not abort; it only blocks the next pop.
- Reset mid-transfer: outputs drop to 0 immediately (async); the queued commands are lost.
- busy is combinational from state and count.

Decomposition:
- Shared package holds:
  - SELW.
  - Source code constants SRC_A=0, SRC_B=1, SRC_IN=2.
  - Destination code constants DST_A=0, DST_B=1, DST_OUT=2.
  - The FSM state encoding.
- One sub-module: cmd_fifo (parameterised DEPTH and width 2*SELW, push/pop/full/empty/count, async active-low reset).
- FSM and output registers live in bus_sequencer.

Test Plan:
- Reset: hold rst=0 for 3 cycles with cmd_valid=1 → all outputs 0, cmd_ready=0; release → cmd_ready=1 next cycle, no transfer issued until a push.
- Single transfer: push src=2, dst=0 at edge k → selsrc=2, seldst=0, srcen=1, dsten=0 after k+1; dsten=1 after k+2; done=1 after k+3; IDLE with enables 0.
- Back-to-back: push (0→1), (1→2), (2→0) on consecutive cycles → dsten high every other cycle for 3 pulses, done pulses at 3 distinct cycles, srcen continuous for 6 cycles.
- Full/backpressure: halt=1, push 4 commands → cmd_ready=0 after the 4th; 5th cmd_valid ignored; deassert halt → exactly 4 transfers in order.
- Illegal code: push (src=5, dst=1) then (0→2) → err pulses once, no dsten for the first; second completes normally.
- Mid-transfer reset: assert rst=0 during LATCH with 2 queued → srcen/dsten drop in the same cycle; after release, busy=0 and no transfers occur.
